scan_capture_regbank: RTL and testbench
=======================================

SCAN_CAPTURE_REGBANK -- requirements
Module: scan_capture_regbank

Interface
REQ-001 Parameter P_SC_NBR, 4: number of scan chains, 1..16.
REQ-002 Parameter P_SC_DEPTH, 8: capture words per chain, power of two, 2..64.
REQ-003 Parameter P_IN_WORDS, 8: 32-bit DUT input words, 1..16.
REQ-004 Parameter P_OUT_WORDS, 8: 32-bit DUT output words, 1..16.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr_en  in  1  bus write strobe.
REQ-008 wr_addr  in  32  bus write word address.
REQ-009 wr_data  in  32  bus write data.
REQ-010 rd_en  in  1  bus read strobe.
REQ-011 rd_addr  in  32  bus read word address.
REQ-012 rd_data  out  32  registered read data.
REQ-013 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-014 rd_err  out  1  high with rd_valid when the read address is unmapped.
REQ-015 dut_input_vec  out  32*P_IN_WORDS  DUT_IN words; word k on bits [32k+31:32k].
REQ-016 dut_output_vec  in  32*P_OUT_WORDS  DUT output vector, same packing.
REQ-017 dut_output_capture  in  1  snapshot strobe for dut_output_vec.
REQ-018 dft_valid  in  P_SC_NBR  per-chain capture strobe.
REQ-019 dft_data  in  32*P_SC_NBR  per-chain capture word; chain i on [32i+31:32i].
REQ-020 dft_full  out  P_SC_NBR  per-chain buffer-full flag.
REQ-021 ctrl_state  in  32  controller state, readable over the bus.
REQ-022 ctrl_opcode  out  32  OPCODE register contents.
REQ-023 ctrl_config  out  32  CONFIG register contents.
REQ-024 opcode_valid  out  1  one-cycle pulse after each OPCODE write.

Function
REQ-025 The address map SHALL be: 0x0 OPCODE (RW), 0x1 STATE (RO), 0x2 CONFIG (RW), 0x3 STATUS (RO), 0x4 CLEAR (WO; reads return 0 with no error), 0x10+k DUT_IN (RW, k<P_IN_WORDS), 0x20+k DUT_OUT (RO, k<P_OUT_WORDS), 0x100+i*P_SC_DEPTH+j DFT buffer (RO, chain i, slot j); every other address is unmapped.
REQ-026 Writes SHALL complete in one cycle, with the new value visible on outputs the cycle after wr_en; writes to RO or unmapped addresses SHALL be dropped silently.
REQ-027 An OPCODE write SHALL update ctrl_opcode and pulse opcode_valid for exactly one cycle on the same edge; back-to-back OPCODE writes SHALL pulse opcode_valid on each.
REQ-028 A read SHALL have a latency of one cycle: rd_en at edge N gives rd_data, rd_valid=1 and rd_err after edge N; rd_data SHALL hold until the next read.
REQ-029 An unmapped read SHALL return rd_data=0 with rd_err=1.
REQ-030 A STATE read SHALL return ctrl_state sampled at the rd_en edge.
REQ-031 A same-cycle read and write to the same address SHALL return the old value.
REQ-032 When dut_output_capture=1, all P_OUT_WORDS DUT_OUT words SHALL be latched in parallel on one edge; otherwise they SHALL hold.
REQ-033 Each chain SHALL have a write pointer of log2(P_SC_DEPTH)+1 bits; dft_valid[i] with the chain not full SHALL store dft_data[i] at slot ptr and increment ptr.
REQ-034 dft_full[i] SHALL equal (ptr_i == P_SC_DEPTH); dft_valid[i] while full SHALL drop the data and set the sticky overflow[i] bit; the pointer SHALL NOT wrap.
REQ-035 STATUS SHALL read {overflow[15:0], full[15:0]}, with bits for nonexistent chains at 0.
REQ-036 A CLEAR write SHALL, for each bit i set in wr_data[15:0], zero ptr_i, full and overflow[i] on that edge; buffer contents SHALL be retained.
REQ-037 If a CLEAR and dft_valid[i] hit the same chain in the same cycle, the clear SHALL win and the data SHALL be dropped.
REQ-038 Reading slots at or above ptr SHALL return the stale stored value with no error.

Reset
REQ-039 Asserting reset SHALL immediately zero all registers, buffers, pointers, overflow bits, rd_data, rd_valid, rd_err, opcode_valid and dft_full, including when an operation is in progress.
REQ-040 On the first edge after reset deasserts, normal operation SHALL begin with no spurious pulse.

Verification
REQ-041 Write 0x5 to 0x0 -> ctrl_opcode=0x5 and opcode_valid high for one cycle; read 0x0 -> rd_data=0x5 one cycle after rd_en.
REQ-042 Drive 9 dft_valid on chain 1 with data 1..9 (P_SC_DEPTH=8) -> dft_full[1]=1 after the 8th; STATUS=0x0002_0002; reading 0x108..0x10F returns 1..8.
REQ-043 Write CLEAR 0x2 with dft_valid[1] in the same cycle -> STATUS=0 and ptr=0; the next valid word lands at slot 0.
REQ-044 Pulse dut_output_capture with dut_output_vec words k=0xA0+k -> reading 0x20..0x27 returns 0xA0..0xA7; changing the input with no capture leaves the reads unchanged.
REQ-045 Read 0x5 and 0x1000 -> rd_data=0 and rd_err=1; read 0x4 -> rd_data=0 and rd_err=0.
REQ-046 Assert reset mid-fill of chain 0 -> all outputs 0 the same cycle; after release STATUS=0.

Source files
------------

// File: rtl/scan_capture_regbank.sv
// Scan-capture register bank: bus-accessible control registers, DUT input
// drive words, parallel DUT output snapshot, and per-chain DFT capture
// buffers with full/overflow tracking.
module scan_capture_regbank #(
  parameter int P_SC_NBR    = 4,
  parameter int P_SC_DEPTH  = 8,
  parameter int P_IN_WORDS  = 8,
  parameter int P_OUT_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  input  logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [32*P_IN_WORDS-1:0] dut_input_vec,
  input  logic [32*P_OUT_WORDS-1:0] dut_output_vec,
  input  logic                     dut_output_capture,
  input  logic [P_SC_NBR-1:0]      dft_valid,
  input  logic [32*P_SC_NBR-1:0]   dft_data,
  output logic [P_SC_NBR-1:0]      dft_full,
  input  logic [31:0]              ctrl_state,
  output logic [31:0]              ctrl_opcode,
  output logic [31:0]              ctrl_config,
  output logic                     opcode_valid
);

  // Slot index width, pointer width (one extra bit so "full" is representable),
  // chain index width, and the width of a buffer-region offset.
  localparam int AW = $clog2(P_SC_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (P_SC_NBR > 1) ? $clog2(P_SC_NBR) : 1;
  localparam int OW = AW + CW;
  localparam logic [31:0] BUF_BASE = 32'h100;
  localparam logic [31:0] BUF_END  = 32'h100 + 32'(P_SC_NBR * P_SC_DEPTH);

  logic [31:0] opcode_q;
  logic [31:0] config_q;
  logic        opcode_valid_q;
  logic [31:0] din_q  [P_IN_WORDS];
  logic [31:0] dout_q [P_OUT_WORDS];
  logic [31:0] chain_rd [P_SC_NBR];
  logic [P_SC_NBR-1:0] ovf_vec;
  logic [P_SC_NBR-1:0] full_vec;

  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q;
  logic        rd_err_q, rd_err_d;

  logic wr_opcode, wr_config, wr_clear;
  assign wr_opcode = wr_en && (wr_addr == 32'h0);
  assign wr_config = wr_en && (wr_addr == 32'h2);
  assign wr_clear  = wr_en && (wr_addr == 32'h4);

  // Buffer-region offset, truncated to the bits that select chain and slot;
  // the range check on the full address keeps the truncation safe.
  logic [OW-1:0] buf_off;
  logic [AW-1:0] buf_slot;
  logic [CW-1:0] buf_chain;
  assign buf_off   = rd_addr[OW-1:0] - OW'(BUF_BASE);
  assign buf_slot  = buf_off[AW-1:0];
  assign buf_chain = buf_off[OW-1:AW];

  // OPCODE/CONFIG registers and the opcode strobe that accompanies each OPCODE write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q       <= 32'h0;
      config_q       <= 32'h0;
      opcode_valid_q <= 1'b0;
    end else begin
      opcode_valid_q <= wr_opcode;
      if (wr_opcode) opcode_q <= wr_data;
      if (wr_config) config_q <= wr_data;
    end
  end

  genvar gi;

  generate
    for (gi = 0; gi < P_IN_WORDS; gi++) begin : g_din
      // DUT input word: written from the bus at 0x10+gi.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) din_q[gi] <= 32'h0;
        else if (wr_en && (wr_addr == 32'h10 + 32'(gi))) din_q[gi] <= wr_data;
      end
      assign dut_input_vec[32*gi +: 32] = din_q[gi];
    end

    for (gi = 0; gi < P_OUT_WORDS; gi++) begin : g_dout
      // DUT output snapshot word: all words load together on the capture strobe.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) dout_q[gi] <= 32'h0;
        else if (dut_output_capture) dout_q[gi] <= dut_output_vec[32*gi +: 32];
      end
    end

    for (gi = 0; gi < P_SC_NBR; gi++) begin : g_chain
      logic [PW-1:0] ptr_q, ptr_d;
      logic          ovf_q, ovf_d;
      logic [31:0]   mem_q [P_SC_DEPTH];
      logic          full, clr, store;

      assign full  = (ptr_q == PW'(P_SC_DEPTH));
      // A clear on this chain pre-empts any same-cycle capture.
      assign clr   = wr_clear && wr_data[gi];
      assign store = dft_valid[gi] && !full && !clr;

      // Pointer/overflow next state: clear wins, pointer saturates at depth.
      always_comb begin
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        if (clr) begin
          ptr_d = '0;
          ovf_d = 1'b0;
        end else if (dft_valid[gi]) begin
          if (full) ovf_d = 1'b1;
          else      ptr_d = ptr_q + PW'(1);
        end
      end

      // Pointer and sticky overflow state.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ptr_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          ptr_q <= ptr_d;
          ovf_q <= ovf_d;
        end
      end

      // Capture buffer: contents survive CLEAR, only reset zeroes them.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int j = 0; j < P_SC_DEPTH; j++) mem_q[j] <= 32'h0;
        end else if (store) begin
          mem_q[ptr_q[AW-1:0]] <= dft_data[32*gi +: 32];
        end
      end

      assign full_vec[gi] = full;
      assign ovf_vec[gi]  = ovf_q;
      assign chain_rd[gi] = mem_q[buf_slot];
    end
  endgenerate

  // Read decode from current register values, so a same-cycle write is not seen.
  always_comb begin
    rd_data_d = 32'h0;
    rd_err_d  = 1'b1;
    case (rd_addr)
      32'h0: begin rd_data_d = opcode_q;   rd_err_d = 1'b0; end
      32'h1: begin rd_data_d = ctrl_state; rd_err_d = 1'b0; end
      32'h2: begin rd_data_d = config_q;   rd_err_d = 1'b0; end
      32'h3: begin rd_data_d = {16'(ovf_vec), 16'(full_vec)}; rd_err_d = 1'b0; end
      32'h4: begin rd_data_d = 32'h0;      rd_err_d = 1'b0; end
      default: ;
    endcase
    for (int k = 0; k < P_IN_WORDS; k++) begin
      if (rd_addr == 32'h10 + 32'(k)) begin
        rd_data_d = din_q[k];
        rd_err_d  = 1'b0;
      end
    end
    for (int k = 0; k < P_OUT_WORDS; k++) begin
      if (rd_addr == 32'h20 + 32'(k)) begin
        rd_data_d = dout_q[k];
        rd_err_d  = 1'b0;
      end
    end
    if (rd_addr >= BUF_BASE && rd_addr < BUF_END) begin
      rd_err_d = 1'b0;
      for (int i = 0; i < P_SC_NBR; i++) begin
        if (buf_chain == CW'(i)) rd_data_d = chain_rd[i];
      end
    end
  end

  // Registered read port: data holds between reads, valid/err pulse with each read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_en && rd_err_d;
      if (rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_err       = rd_err_q;
  assign ctrl_opcode  = opcode_q;
  assign ctrl_config  = config_q;
  assign opcode_valid = opcode_valid_q;
  assign dft_full     = full_vec;

endmodule

// File: tb/tb_scan_capture_regbank.sv
// Directed self-checking bench for scan_capture_regbank (default parameters).
module tb_scan_capture_regbank;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [31:0]   wr_addr, wr_data;
  logic          rd_en;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid, rd_err;
  logic [255:0]  dut_input_vec;
  logic [255:0]  dut_output_vec;
  logic          dut_output_capture;
  logic [3:0]    dft_valid;
  logic [127:0]  dft_data;
  logic [3:0]    dft_full;
  logic [31:0]   ctrl_state, ctrl_opcode, ctrl_config;
  logic          opcode_valid;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] rdv;
  logic        rde, rdvl;

  scan_capture_regbank dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .dut_input_vec(dut_input_vec), .dut_output_vec(dut_output_vec),
    .dut_output_capture(dut_output_capture),
    .dft_valid(dft_valid), .dft_data(dft_data), .dft_full(dft_full),
    .ctrl_state(ctrl_state), .ctrl_opcode(ctrl_opcode), .ctrl_config(ctrl_config),
    .opcode_valid(opcode_valid)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    $display("[TB] write addr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic e, output logic v);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    d = rd_data; e = rd_err; v = rd_valid;
    @(negedge clk);
    rd_en = 1'b0;
    $display("[TB] read  addr=0x%0h data=0x%0h err=%0b valid=%0b", a, d, e, v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({rd_data, rd_valid, rd_err, opcode_valid, dft_full, ctrl_opcode, ctrl_config} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got rd_data=0x%0h rd_valid=%0b rd_err=%0b ov=%0b full=%0h op=0x%0h cfg=0x%0h expected all 0",
               rd_data, rd_valid, rd_err, opcode_valid, dft_full, ctrl_opcode, ctrl_config);
    end
    tests_run++;
    if (dut_input_vec !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_din got 0x%0h expected 0", dut_input_vec);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_pulse got ov=%0b rv=%0b expected 0 0", opcode_valid, rd_valid);
    end
  endtask

  task automatic test_opcode();
    // Back-to-back OPCODE writes 6 then 7.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'h6;
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b1 || ctrl_opcode !== 32'h6) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first got ov=%0b op=0x%0h expected 1 0x6", opcode_valid, ctrl_opcode);
    end
    @(negedge clk);
    wr_data = 32'h7;
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b1 || ctrl_opcode !== 32'h7) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second got ov=%0b op=0x%0h expected 1 0x7", opcode_valid, ctrl_opcode);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_end got ov=%0b expected 0", opcode_valid);
    end
    $display("[TB] back-to-back opcode writes 0x6, 0x7");
    // Single OPCODE write of 5.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'h5;
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b1 || ctrl_opcode !== 32'h5) begin
      tests_failed++;
      $display("[TB] FAIL opcode_write got ov=%0b op=0x%0h expected 1 0x5", opcode_valid, ctrl_opcode);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL opcode_pulse_width got ov=%0b expected 0", opcode_valid);
    end
    bus_read(32'h0, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h5 || rde !== 1'b0 || rdvl !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL opcode_read got 0x%0h err=%0b v=%0b expected 0x5 0 1", rdv, rde, rdvl);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h5) begin
      tests_failed++;
      $display("[TB] FAIL read_hold got v=%0b data=0x%0h expected 0 0x5", rd_valid, rd_data);
    end
  endtask

  task automatic test_state_config();
    ctrl_state = 32'hABCD0001;
    bus_read(32'h1, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'hABCD0001 || rde !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL state_read got 0x%0h err=%0b expected 0xabcd0001 0", rdv, rde);
    end
    bus_write(32'h1, 32'h0BAD0BAD);
    bus_read(32'h1, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'hABCD0001) begin
      tests_failed++;
      $display("[TB] FAIL state_ro got 0x%0h expected 0xabcd0001", rdv);
    end
    bus_write(32'h2, 32'h11111111);
    tests_run++;
    if (ctrl_config !== 32'h11111111) begin
      tests_failed++;
      $display("[TB] FAIL config_write got 0x%0h expected 0x11111111", ctrl_config);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h2; wr_data = 32'h22222222;
    rd_en = 1'b1; rd_addr = 32'h2;
    @(posedge clk); #1;
    tests_run++;
    if (rd_data !== 32'h11111111 || ctrl_config !== 32'h22222222) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_rw got rd=0x%0h cfg=0x%0h expected 0x11111111 0x22222222", rd_data, ctrl_config);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    $display("[TB] same-cycle read/write of CONFIG");
    bus_read(32'h2, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h22222222) begin
      tests_failed++;
      $display("[TB] FAIL config_read got 0x%0h expected 0x22222222", rdv);
    end
  endtask

  task automatic test_din();
    bus_write(32'h13, 32'hCAFE0003);
    tests_run++;
    if (dut_input_vec[127:96] !== 32'hCAFE0003 || dut_input_vec[31:0] !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL din_vec got w3=0x%0h w0=0x%0h expected 0xcafe0003 0", dut_input_vec[127:96], dut_input_vec[31:0]);
    end
    bus_read(32'h13, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'hCAFE0003 || rde !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL din_read got 0x%0h err=%0b expected 0xcafe0003 0", rdv, rde);
    end
    bus_read(32'h18, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0 || rde !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL din_oob got 0x%0h err=%0b expected 0 1", rdv, rde);
    end
  endtask

  task automatic test_dft_fill();
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      dft_valid = 4'b0010;
      dft_data = '0;
      dft_data[63:32] = 32'(n);
      @(posedge clk); #1;
      if (n == 7) begin
        tests_run++;
        if (dft_full !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL dft_not_full_at_7 got 0x%0h expected 0x0", dft_full);
        end
      end
      if (n == 8) begin
        tests_run++;
        if (dft_full !== 4'b0010) begin
          tests_failed++;
          $display("[TB] FAIL dft_full_at_8 got 0x%0h expected 0x2", dft_full);
        end
      end
      $display("[TB] dft chain1 push %0d full=0x%0h", n, dft_full);
    end
    @(negedge clk);
    dft_valid = 4'b0000;
    bus_read(32'h3, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h00020002 || rde !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL status_overflow got 0x%0h err=%0b expected 0x00020002 0", rdv, rde);
    end
    for (int j = 0; j < 8; j++) begin
      bus_read(32'h108 + 32'(j), rdv, rde, rdvl);
      tests_run++;
      if (rdv !== 32'(j + 1) || rde !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL dft_slot%0d got 0x%0h err=%0b expected 0x%0h 0", j, rdv, rde, j + 1);
      end
    end
  endtask

  task automatic test_clear_collision();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h2;
    dft_valid = 4'b0010; dft_data = '0; dft_data[63:32] = 32'h77;
    @(posedge clk); #1;
    tests_run++;
    if (dft_full !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL clear_full got 0x%0h expected 0x0", dft_full);
    end
    @(negedge clk);
    wr_en = 1'b0; dft_valid = 4'b0000;
    $display("[TB] CLEAR 0x2 with chain1 valid in same cycle");
    bus_read(32'h3, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL clear_status got 0x%0h expected 0x0", rdv);
    end
    @(negedge clk);
    dft_valid = 4'b0010; dft_data[63:32] = 32'h55;
    @(negedge clk);
    dft_valid = 4'b0000;
    $display("[TB] dft chain1 push 0x55");
    bus_read(32'h108, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h55) begin
      tests_failed++;
      $display("[TB] FAIL clear_slot0 got 0x%0h expected 0x55", rdv);
    end
    bus_read(32'h109, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h2 || rde !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stale_slot1 got 0x%0h err=%0b expected 0x2 0", rdv, rde);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    for (int k = 0; k < 8; k++) dut_output_vec[32*k +: 32] = 32'hA0 + 32'(k);
    dut_output_capture = 1'b1;
    @(negedge clk);
    dut_output_capture = 1'b0;
    for (int k = 0; k < 8; k++) dut_output_vec[32*k +: 32] = 32'hFFFF0000 + 32'(k);
    $display("[TB] capture pulse with words 0xA0+k");
    for (int k = 0; k < 8; k++) begin
      bus_read(32'h20 + 32'(k), rdv, rde, rdvl);
      tests_run++;
      if (rdv !== 32'hA0 + 32'(k) || rde !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL dout_word%0d got 0x%0h err=%0b expected 0x%0h 0", k, rdv, rde, 32'hA0 + k);
      end
    end
    bus_write(32'h20, 32'h1234);
    bus_read(32'h20, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'hA0) begin
      tests_failed++;
      $display("[TB] FAIL dout_ro got 0x%0h expected 0xa0", rdv);
    end
  endtask

  task automatic test_unmapped();
    bus_read(32'h5, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0 || rde !== 1'b1 || rdvl !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_0x5 got 0x%0h err=%0b v=%0b expected 0 1 1", rdv, rde, rdvl);
    end
    bus_read(32'h1000, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0 || rde !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_0x1000 got 0x%0h err=%0b expected 0 1", rdv, rde);
    end
    bus_read(32'h120, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0 || rde !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_0x120 got 0x%0h err=%0b expected 0 1", rdv, rde);
    end
    bus_read(32'h4, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0 || rde !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_read got 0x%0h err=%0b expected 0 0", rdv, rde);
    end
  endtask

  task automatic test_reset_midfill();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      dft_valid = 4'b0001;
      dft_data = '0; dft_data[31:0] = 32'h900 + 32'(n);
    end
    @(negedge clk);
    dft_valid = 4'b0000;
    bus_read(32'h100, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h900 || dft_full !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL prefill got 0x%0h full=0x%0h expected 0x900 0x1", rdv, dft_full);
    end
    // Keep capture and a read going while reset hits mid-cycle.
    @(negedge clk);
    dft_valid = 4'b0001; rd_en = 1'b1; rd_addr = 32'h100;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({rd_data, rd_valid, rd_err, opcode_valid, dft_full, ctrl_opcode, ctrl_config} !== '0 ||
        dut_input_vec !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async got rd=0x%0h v=%0b full=0x%0h op=0x%0h cfg=0x%0h din_nz=%0b expected all 0",
               rd_data, rd_valid, dft_full, ctrl_opcode, ctrl_config, |dut_input_vec);
    end
    @(negedge clk);
    dft_valid = 4'b0000; rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset asserted mid-fill and released");
    @(posedge clk); #1;
    tests_run++;
    if (opcode_valid !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_pulse got ov=%0b rv=%0b expected 0 0", opcode_valid, rd_valid);
    end
    bus_read(32'h3, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_status got 0x%0h expected 0x0", rdv);
    end
    bus_read(32'h100, rdv, rde, rdvl);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_buffer got 0x%0h expected 0x0", rdv);
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    dut_output_vec = '0; dut_output_capture = 1'b0;
    dft_valid = '0; dft_data = '0;
    ctrl_state = '0;
    test_reset();
    test_opcode();
    test_state_config();
    test_same_cycle();
    test_din();
    test_dft_fill();
    test_clear_collision();
    test_capture();
    test_unmapped();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
